// File: rtl/isf_pkg.sv
// Shared constants, state encoding and mod-N_BITS helper for initial_shift_fetch.
package isf_pkg;

  localparam int N_BITS          = 17669;
  localparam int LAST_WORD_IDX   = 552;
  localparam int PENULT_WORD_IDX = 551;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CALC      = 3'd1;
  localparam logic [2:0] ST_READ0     = 3'd2;
  localparam logic [2:0] ST_READ1     = 3'd3;
  localparam logic [2:0] ST_READ2     = 3'd4;
  localparam logic [2:0] ST_CAPTURE   = 3'd5;
  localparam logic [2:0] ST_START     = 3'd6;
  localparam logic [2:0] ST_WAIT_DONE = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    CALC      = ST_CALC,
    READ0     = ST_READ0,
    READ1     = ST_READ1,
    READ2     = ST_READ2,
    CAPTURE   = ST_CAPTURE,
    START     = ST_START,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  // 17-bit sum so the wrap compare never overflows before subtracting N_BITS.
  function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 17'(N_BITS)) ? 16'(sum - 17'(N_BITS)) : sum[15:0];
  endfunction

endpackage

// File: rtl/isf_shift_calc.sv
// Combinational position -> shift / word index / bit-in-word calculator.
module isf_shift_calc
  import isf_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [15:0]       pos,
  output logic [15:0]       high_shift,
  output logic [15:0]       low_shift,
  output logic [ADDR_W-1:0] idx_high,
  output logic [ADDR_W-1:0] idx_low,
  output logic [4:0]        sh_high,
  output logic [4:0]        sh_low
);

  assign high_shift = pos;
  assign low_shift  = mod_add(pos, 16'd32);
  assign idx_high   = high_shift[ADDR_W+4:5];
  assign idx_low    = low_shift[ADDR_W+4:5];
  assign sh_high    = high_shift[4:0];
  assign sh_low     = low_shift[4:0];

endmodule

// File: rtl/initial_shift_fetch.sv
// Fetches normal words 0/551/552 and two acc words, then launches one shift job.
// Optional ISF_NORMAL_CACHE_EN keeps the normal words across jobs.
module initial_shift_fetch
  import isf_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pos_valid,
  output logic                  pos_ready,
  input  logic [15:0]           pos,
  input  logic                  normal_reload,
  output logic                  normal_rd_en,
  output logic [ADDR_W-1:0]     normal_rd_addr,
  input  logic [WORD_WIDTH-1:0] normal_rd_data,
  output logic                  acc_rd_en,
  output logic [ADDR_W-1:0]     acc_rd_addr,
  input  logic [WORD_WIDTH-1:0] acc_rd_data,
  output logic [WORD_WIDTH-1:0] normal_word_zero,
  output logic [WORD_WIDTH-1:0] normal_word_551,
  output logic [WORD_WIDTH-1:0] normal_word_552,
  output logic [WORD_WIDTH-1:0] acc_word_high,
  output logic [WORD_WIDTH-1:0] acc_word_low,
  output logic [15:0]           high_shift,
  output logic [15:0]           low_shift,
  output logic [ADDR_W-1:0]     acc_start_idx_high,
  output logic [ADDR_W-1:0]     acc_start_idx_low,
  output logic [4:0]            acc_shift_idx_high,
  output logic [4:0]            acc_shift_idx_low,
  output logic                  start_process,
  input  logic                  processing_done,
  output logic                  pos_err
);

  state_t                  state_q, state_d;
  logic [15:0]             pos_q, pos_d;
  logic [15:0]             high_shift_q, high_shift_d, low_shift_q, low_shift_d;
  logic [ADDR_W-1:0]       idx_high_q, idx_high_d, idx_low_q, idx_low_d;
  logic [4:0]              sh_high_q, sh_high_d, sh_low_q, sh_low_d;
  logic [WORD_WIDTH-1:0]   w0_q, w0_d, w551_q, w551_d, w552_q, w552_d;
  logic [WORD_WIDTH-1:0]   acc_high_q, acc_high_d, acc_low_q, acc_low_d;
  logic                    pos_err_q, pos_err_d;
  logic                    hit;

  logic [15:0]             c_high_shift, c_low_shift;
  logic [ADDR_W-1:0]       c_idx_high, c_idx_low;
  logic [4:0]              c_sh_high, c_sh_low;

`ifdef ISF_NORMAL_CACHE_EN
  logic hit_q, hit_d, cache_valid_q, cache_valid_d, reload_pend_q, reload_pend_d;
  assign hit = hit_q;
`else
  logic unused_normal_reload;
  assign unused_normal_reload = normal_reload;
  assign hit = 1'b0;
`endif

  isf_shift_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pos        (pos_q),
    .high_shift (c_high_shift),
    .low_shift  (c_low_shift),
    .idx_high   (c_idx_high),
    .idx_low    (c_idx_low),
    .sh_high    (c_sh_high),
    .sh_low     (c_sh_low)
  );

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    high_shift_d = high_shift_q;
    low_shift_d  = low_shift_q;
    idx_high_d   = idx_high_q;
    idx_low_d    = idx_low_q;
    sh_high_d    = sh_high_q;
    sh_low_d     = sh_low_q;
    w0_d         = w0_q;
    w551_d       = w551_q;
    w552_d       = w552_q;
    acc_high_d   = acc_high_q;
    acc_low_d    = acc_low_q;
    pos_err_d    = pos_err_q;
    pos_ready      = 1'b0;
    normal_rd_en   = 1'b0;
    normal_rd_addr = '0;
    acc_rd_en      = 1'b0;
    acc_rd_addr    = '0;
    start_process  = 1'b0;
`ifdef ISF_NORMAL_CACHE_EN
    hit_d         = hit_q;
    cache_valid_d = cache_valid_q;
    reload_pend_d = reload_pend_q | normal_reload;
`endif

    case (state_q)
      IDLE: begin
        pos_ready = 1'b1;
        if (pos_valid) begin
          if (pos >= 16'(N_BITS)) begin
            pos_err_d = 1'b1;
          end else begin
            pos_d   = pos;
            state_d = CALC;
`ifdef ISF_NORMAL_CACHE_EN
            // A reload seen before this accept forces a refetch; later ones wait for the next job.
            hit_d         = cache_valid_q & ~reload_pend_q & ~normal_reload;
            reload_pend_d = 1'b0;
`endif
          end
        end
      end
      CALC: begin
        high_shift_d = c_high_shift;
        low_shift_d  = c_low_shift;
        idx_high_d   = c_idx_high;
        idx_low_d    = c_idx_low;
        sh_high_d    = c_sh_high;
        sh_low_d     = c_sh_low;
        state_d      = READ0;
      end
      READ0: begin
        normal_rd_en = ~hit;
        acc_rd_en    = 1'b1;
        acc_rd_addr  = idx_high_q;
        state_d      = READ1;
      end
      READ1: begin
        acc_high_d = acc_rd_data;
        if (!hit) w0_d = normal_rd_data;
        normal_rd_en   = ~hit;
        normal_rd_addr = hit ? '0 : ADDR_W'(PENULT_WORD_IDX);
        acc_rd_en      = 1'b1;
        acc_rd_addr    = idx_low_q;
        state_d        = hit ? CAPTURE : READ2;
      end
      READ2: begin
        w551_d         = normal_rd_data;
        acc_low_d      = acc_rd_data;
        normal_rd_en   = 1'b1;
        normal_rd_addr = ADDR_W'(LAST_WORD_IDX);
        state_d        = CAPTURE;
      end
      CAPTURE: begin
        if (hit) begin
          acc_low_d = acc_rd_data;
        end else begin
          w552_d = normal_rd_data;
`ifdef ISF_NORMAL_CACHE_EN
          cache_valid_d = 1'b1;
`endif
        end
        state_d = START;
      end
      START: begin
        start_process = 1'b1;
        state_d       = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (processing_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      high_shift_q <= '0;
      low_shift_q  <= '0;
      idx_high_q   <= '0;
      idx_low_q    <= '0;
      sh_high_q    <= '0;
      sh_low_q     <= '0;
      w0_q         <= '0;
      w551_q       <= '0;
      w552_q       <= '0;
      acc_high_q   <= '0;
      acc_low_q    <= '0;
      pos_err_q    <= 1'b0;
`ifdef ISF_NORMAL_CACHE_EN
      hit_q         <= 1'b0;
      cache_valid_q <= 1'b0;
      reload_pend_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      high_shift_q <= high_shift_d;
      low_shift_q  <= low_shift_d;
      idx_high_q   <= idx_high_d;
      idx_low_q    <= idx_low_d;
      sh_high_q    <= sh_high_d;
      sh_low_q     <= sh_low_d;
      w0_q         <= w0_d;
      w551_q       <= w551_d;
      w552_q       <= w552_d;
      acc_high_q   <= acc_high_d;
      acc_low_q    <= acc_low_d;
      pos_err_q    <= pos_err_d;
`ifdef ISF_NORMAL_CACHE_EN
      hit_q         <= hit_d;
      cache_valid_q <= cache_valid_d;
      reload_pend_q <= reload_pend_d;
`endif
    end
  end

  assign normal_word_zero   = w0_q;
  assign normal_word_551    = w551_q;
  assign normal_word_552    = w552_q;
  assign acc_word_high      = acc_high_q;
  assign acc_word_low       = acc_low_q;
  assign high_shift         = high_shift_q;
  assign low_shift          = low_shift_q;
  assign acc_start_idx_high = idx_high_q;
  assign acc_start_idx_low  = idx_low_q;
  assign acc_shift_idx_high = sh_high_q;
  assign acc_shift_idx_low  = sh_low_q;
  assign pos_err            = pos_err_q;

endmodule
